// File: rtl/microseq_ctrl_if.sv
// Sequencer-side bundle: start/stall control, condition inputs, microcode load
// port and the registered control-word outputs.
interface microseq_ctrl_if #(
  parameter int AW    = 6,
  parameter int CW    = 32,
  parameter int NFLAG = 2
);
  localparam int SW = ($clog2(NFLAG) > 1) ? $clog2(NFLAG) : 1;
  localparam int W  = 3 + SW + AW + CW;

  logic             start;
  logic             stall;
  logic [NFLAG-1:0] flags;
  logic [AW-1:0]    opcode;
  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [W-1:0]     ld_data;
  logic [CW-1:0]    ctrl_out;
  logic             ctrl_valid;
  logic [AW-1:0]    upa;
  logic             finish;
  logic             err;

  modport master (
    output start, stall, flags, opcode, ld_en, ld_addr, ld_data,
    input  ctrl_out, ctrl_valid, upa, finish, err
  );

  modport slave (
    input  start, stall, flags, opcode, ld_en, ld_addr, ld_data,
    output ctrl_out, ctrl_valid, upa, finish, err
  );
endinterface

// File: rtl/microseq_ctrl.sv
// Microprogram sequencer: writable control store, conditional branches,
// opcode dispatch and a bounded subroutine return stack.
module microseq_ctrl #(
  parameter int AW         = 6,
  parameter int CW         = 32,
  parameter int NFLAG      = 2,
  parameter int SDEPTH     = 4,
  parameter int START_ADDR = 0
) (
  input logic            clk,
  input logic            rst_n,
  microseq_ctrl_if.slave bus
);
  localparam int SW  = ($clog2(NFLAG) > 1) ? $clog2(NFLAG) : 1;
  localparam int W   = 3 + SW + AW + CW;
  localparam int SPW = $clog2(SDEPTH + 1);
  localparam int IW  = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
  localparam logic [AW-1:0] START = AW'(START_ADDR);

  localparam logic [2:0] M_SEQ  = 3'd0;
  localparam logic [2:0] M_JUMP = 3'd1;
  localparam logic [2:0] M_DISP = 3'd2;
  localparam logic [2:0] M_BRT  = 3'd3;
  localparam logic [2:0] M_BRF  = 3'd4;
  localparam logic [2:0] M_CALL = 3'd5;
  localparam logic [2:0] M_RET  = 3'd6;
  localparam logic [2:0] M_HALT = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state;
  logic [W-1:0]   store [2**AW];
  logic [AW-1:0]  stack [SDEPTH];
  logic [SPW-1:0] sp;
  logic           halt_pend;
  logic [AW-1:0]  upa_p0;
  logic [CW-1:0]  ctrl_p1;
  logic           vld_p1;
  logic           finish_q;
  logic           err_q;

  logic [W-1:0]        word;
  logic [2:0]          mode;
  logic [SW-1:0]       csel;
  logic [AW-1:0]       nxt;
  logic [CW-1:0]       wctrl;
  logic [AW-1:0]       upa_inc;
  logic [(1<<SW)-1:0]  flags_ext;
  logic                flag_sel;
  logic                full;
  logic                empty;
  logic [IW-1:0]       top_idx;
  logic [IW-1:0]       push_idx;
  logic [AW-1:0]       next_upa;
  logic                do_push;
  logic                do_pop;
  logic                fault;
  logic                is_halt;
  logic                advance;

  // Fetch stage: decode the word addressed by the current microaddress
  assign word             = store[upa_p0];
  assign {mode, csel, nxt, wctrl} = word;
  assign upa_inc          = upa_p0 + AW'(1);
  assign full             = (sp == SPW'(SDEPTH));
  assign empty            = (sp == '0);
  assign top_idx          = IW'(sp - SPW'(1));
  assign push_idx         = IW'(sp);
  assign advance          = (state == S_RUN) && !bus.stall && !halt_pend;

  // Selects beyond the implemented flags read as 0
  always_comb begin
    flags_ext              = '0;
    flags_ext[NFLAG-1:0]   = bus.flags;
  end
  assign flag_sel = flags_ext[csel];

  always_comb begin
    next_upa = upa_inc;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    fault    = 1'b0;
    is_halt  = 1'b0;
    case (mode)
      M_SEQ:  next_upa = upa_inc;
      M_JUMP: next_upa = nxt;
      M_DISP: next_upa = bus.opcode;
      M_BRT:  if (flag_sel) next_upa = nxt;
      M_BRF:  if (!flag_sel) next_upa = nxt;
      M_CALL: begin
        if (full) begin
          fault = 1'b1;
        end else begin
          do_push  = 1'b1;
          next_upa = nxt;
        end
      end
      M_RET: begin
        if (empty) begin
          fault = 1'b1;
        end else begin
          do_pop   = 1'b1;
          next_upa = stack[top_idx];
        end
      end
      M_HALT: begin
        is_halt  = 1'b1;
        next_upa = upa_p0;
      end
      default: next_upa = upa_inc;
    endcase
  end

  // Control store and return stack hold data only; reset leaves them intact
  always_ff @(posedge clk) begin
    if (bus.ld_en && (state != S_RUN)) store[bus.ld_addr] <= bus.ld_data;
  end

  always_ff @(posedge clk) begin
    if (advance && do_push) stack[push_idx] <= upa_inc;
  end

  // Sequencer stage: state, microaddress, stack pointer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      upa_p0    <= START;
      ctrl_p1   <= '0;
      vld_p1    <= 1'b0;
      finish_q  <= 1'b0;
      err_q     <= 1'b0;
      sp        <= '0;
      halt_pend <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (!bus.stall) begin
            if (halt_pend || fault) begin
              // HALT word already presented for its one cycle, or stack fault
              state     <= S_DONE;
              finish_q  <= 1'b1;
              ctrl_p1   <= '0;
              vld_p1    <= 1'b0;
              halt_pend <= 1'b0;
              if (!halt_pend) err_q <= 1'b1;
            end else begin
              ctrl_p1   <= wctrl;
              vld_p1    <= 1'b1;
              upa_p0    <= next_upa;
              halt_pend <= is_halt;
              if (do_push) sp <= sp + SPW'(1);
              else if (do_pop) sp <= sp - SPW'(1);
            end
          end
        end
        default: begin
          ctrl_p1 <= '0;
          vld_p1  <= 1'b0;
          if (bus.start) begin
            state     <= S_RUN;
            upa_p0    <= START;
            sp        <= '0;
            err_q     <= 1'b0;
            finish_q  <= 1'b0;
            halt_pend <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.ctrl_out   = ctrl_p1;
  assign bus.ctrl_valid = vld_p1;
  assign bus.upa        = upa_p0;
  assign bus.finish     = finish_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_microseq_ctrl.sv
// Bench for microseq_ctrl: directed scenarios plus randomized lockstep
// comparison against a queue-based behavioural model.
module tb_microseq_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  microseq_ctrl_if bus ();
  microseq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state (defaults: AW=6, CW=32, NFLAG=2, SDEPTH=4, START=0)
  logic [41:0] m_mem [64];
  int          m_st;        // 0 idle, 1 run, 2 done
  int          m_upa;
  logic [31:0] m_ctrl;
  bit          m_vld, m_fin, m_err, m_halting;
  int          m_stk [$];

  function automatic logic [41:0] mw(int mode, int csel, int nxt, logic [31:0] c);
    return {3'(mode), 1'(csel), 6'(nxt), c};
  endfunction

  function automatic logic [40:0] obs();
    return {bus.ctrl_out, bus.ctrl_valid, bus.upa, bus.finish, bus.err};
  endfunction

  function automatic logic [40:0] ex(logic [31:0] c, bit v, int u, bit f, bit e);
    return {c, v, 6'(u), f, e};
  endfunction

  function automatic void model_reset();
    m_st = 0; m_upa = 0; m_ctrl = '0; m_vld = 0; m_fin = 0; m_err = 0;
    m_halting = 0; m_stk.delete();
  endfunction

  function automatic void model_step(bit st, bit stl, logic [1:0] fl, int op,
                                     bit ld, int la, logic [41:0] d);
    logic [41:0] w;
    int seq, nu, nxt, mode;
    bit flag, fault;
    if (m_st != 1) begin
      if (ld) m_mem[la] = d;
      m_ctrl = '0; m_vld = 0;
      if (st) begin
        m_st = 1; m_upa = 0; m_stk.delete(); m_err = 0; m_fin = 0; m_halting = 0;
      end
    end else if (!stl) begin
      if (m_halting) begin
        m_st = 2; m_fin = 1; m_ctrl = '0; m_vld = 0; m_halting = 0;
      end else begin
        w     = m_mem[m_upa];
        mode  = int'(w[41:39]);
        nxt   = int'(w[37:32]);
        flag  = fl[w[38]];
        seq   = (m_upa + 1) % 64;
        nu    = seq;
        fault = 0;
        case (mode)
          1: nu = nxt;
          2: nu = op;
          3: nu = flag ? nxt : seq;
          4: nu = flag ? seq : nxt;
          5: if (m_stk.size() == 4) fault = 1; else begin m_stk.push_back(seq); nu = nxt; end
          6: if (m_stk.size() == 0) fault = 1; else nu = m_stk.pop_back();
          7: begin nu = m_upa; m_halting = 1; end
          default: nu = seq;
        endcase
        if (fault) begin
          m_err = 1; m_st = 2; m_fin = 1; m_ctrl = '0; m_vld = 0;
        end else begin
          m_ctrl = w[31:0]; m_vld = 1; m_upa = nu;
        end
      end
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(int a, logic [41:0] d);
    bus.ld_en = 1'b1; bus.ld_addr = 6'(a); bus.ld_data = d;
    cyc();
    bus.ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [40:0] e;
    rst_n = 1'b0;
    bus.start = 0; bus.stall = 0; bus.flags = '0; bus.opcode = '0;
    bus.ld_en = 0; bus.ld_addr = '0; bus.ld_data = '0;
    #1;
    e = ex(0, 0, 0, 0, 0);
    n_total++;
    if (obs() !== e) $display("FAIL reset_async: got %h want %h", obs(), e); else n_pass++;
    @(negedge clk);
    cyc();
    n_total++;
    if (obs() !== e) $display("FAIL reset_held: got %h want %h", obs(), e); else n_pass++;
    rst_n = 1'b1;
    cyc();
    n_total++;
    if (obs() !== e) $display("FAIL reset_idle: got %h want %h", obs(), e); else n_pass++;
  endtask

  task automatic test_seq_chain();
    logic [40:0] e [6];
    load(0, mw(0, 0, 0, 32'hA));
    load(1, mw(0, 0, 0, 32'hB));
    load(2, mw(0, 0, 0, 32'hC));
    load(3, mw(7, 0, 0, 32'hD));
    e[0] = ex(0, 0, 0, 0, 0);
    e[1] = ex(32'hA, 1, 1, 0, 0);
    e[2] = ex(32'hB, 1, 2, 0, 0);
    e[3] = ex(32'hC, 1, 3, 0, 0);
    e[4] = ex(32'hD, 1, 3, 0, 0);
    e[5] = ex(0, 0, 3, 1, 0);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (obs() !== e[i]) $display("FAIL seq_chain c%0d: got %h want %h", i, obs(), e[i]);
      else n_pass++;
      if (i < 5) cyc();
    end
  endtask

  task automatic test_branch();
    logic [40:0] e;
    int mode, csel, fv, tgt;
    load(10, mw(7, 0, 0, 32'h10A));
    load(1, mw(7, 0, 0, 32'h101));
    for (int k = 0; k < 8; k++) begin
      mode = (k & 4) != 0 ? 4 : 3;
      csel = (k >> 1) & 1;
      fv   = k & 1;
      // BRT takes when the selected flag is 1, BRF when it is 0
      tgt  = ((mode == 3) == (fv == 1)) ? 10 : 1;
      load(0, mw(mode, csel, 10, 32'h100 + 32'(k)));
      bus.flags = (csel == 1) ? {1'(fv), 1'(!fv)} : {1'(!fv), 1'(fv)};
      pulse_start();
      cyc();
      e = ex(32'h100 + 32'(k), 1, tgt, 0, 0);
      n_total++;
      if (obs() !== e) $display("FAIL branch k%0d: got %h want %h", k, obs(), e); else n_pass++;
      cyc();
      cyc();
      e = ex(0, 0, tgt, 1, 0);
      n_total++;
      if (obs() !== e) $display("FAIL branch_done k%0d: got %h want %h", k, obs(), e); else n_pass++;
    end
    bus.flags = '0;
  endtask

  task automatic test_dispatch_stall();
    logic [40:0] e;
    load(0, mw(0, 0, 0, 32'h11));
    load(1, mw(2, 0, 0, 32'h22));
    load(42, mw(7, 0, 0, 32'h33));
    pulse_start();
    cyc();
    e = ex(32'h11, 1, 1, 0, 0);
    n_total++;
    if (obs() !== e) $display("FAIL dispatch_pre: got %h want %h", obs(), e); else n_pass++;
    bus.opcode = 6'h2A;
    bus.stall  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_total++;
      if (obs() !== e) $display("FAIL stall c%0d: got %h want %h", i, obs(), e); else n_pass++;
    end
    bus.stall = 1'b0;
    cyc();
    e = ex(32'h22, 1, 42, 0, 0);
    n_total++;
    if (obs() !== e) $display("FAIL dispatch: got %h want %h", obs(), e); else n_pass++;
    cyc();
    cyc();
    e = ex(0, 0, 42, 1, 0);
    n_total++;
    if (obs() !== e) $display("FAIL dispatch_done: got %h want %h", obs(), e); else n_pass++;
    bus.opcode = '0;
  endtask

  task automatic test_stack();
    logic [40:0] e;
    int eu [9] = '{10, 20, 30, 40, 31, 21, 11, 1, 1};
    load(0,  mw(5, 0, 10, 32'd1));
    load(10, mw(5, 0, 20, 32'd2));
    load(20, mw(5, 0, 30, 32'd3));
    load(30, mw(5, 0, 40, 32'd4));
    load(40, mw(6, 0, 0,  32'd5));
    load(31, mw(6, 0, 0,  32'd6));
    load(21, mw(6, 0, 0,  32'd7));
    load(11, mw(6, 0, 0,  32'd8));
    load(1,  mw(7, 0, 0,  32'd9));
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      cyc();
      e = ex(32'(i + 1), 1, eu[i], 0, 0);
      n_total++;
      if (obs() !== e) $display("FAIL nest c%0d: got %h want %h", i, obs(), e); else n_pass++;
    end
    cyc();
    e = ex(0, 0, 1, 1, 0);
    n_total++;
    if (obs() !== e) $display("FAIL nest_done: got %h want %h", obs(), e); else n_pass++;
    // Fifth nested call overflows the four-entry stack
    load(40, mw(5, 0, 50, 32'd5));
    pulse_start();
    for (int i = 0; i < 5; i++) cyc();
    e = ex(0, 0, 40, 1, 1);
    n_total++;
    if (obs() !== e) $display("FAIL overflow: got %h want %h", obs(), e); else n_pass++;
    load(0, mw(6, 0, 0, 32'hEE));
    pulse_start();
    e = ex(0, 0, 0, 0, 0);
    n_total++;
    if (obs() !== e) $display("FAIL err_clear: got %h want %h", obs(), e); else n_pass++;
    cyc();
    e = ex(0, 0, 0, 1, 1);
    n_total++;
    if (obs() !== e) $display("FAIL underflow: got %h want %h", obs(), e); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [40:0] e;
    for (int i = 0; i < 12; i++) load(i, mw(0, 0, 0, 32'h700 + 32'(i)));
    load(12, mw(7, 0, 0, 32'h7FF));
    pulse_start();
    for (int i = 0; i < 20 && bus.upa !== 6'd7; i++) cyc();
    n_total++;
    if (bus.upa !== 6'd7) $display("FAIL reach_upa7: got %0d want 7", bus.upa); else n_pass++;
    rst_n = 1'b0;
    #1;
    e = ex(0, 0, 0, 0, 0);
    n_total++;
    if (obs() !== e) $display("FAIL reset_mid: got %h want %h", obs(), e); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    cyc();
    e = ex(32'h700, 1, 1, 0, 0);
    n_total++;
    if (obs() !== e) $display("FAIL refetch0: got %h want %h", obs(), e); else n_pass++;
    cyc();
    e = ex(32'h701, 1, 2, 0, 0);
    n_total++;
    if (obs() !== e) $display("FAIL refetch1: got %h want %h", obs(), e); else n_pass++;
  endtask

  task automatic test_load_in_run();
    logic [40:0] e;
    load(0, mw(7, 0, 0, 32'hBAD));
    for (int i = 0; i < 40 && bus.finish !== 1'b1; i++) cyc();
    n_total++;
    if (bus.finish !== 1'b1) $display("FAIL run_finish: got %b want 1", bus.finish); else n_pass++;
    pulse_start();
    cyc();
    e = ex(32'h700, 1, 1, 0, 0);
    n_total++;
    if (obs() !== e) $display("FAIL ld_dropped: got %h want %h", obs(), e); else n_pass++;
    for (int i = 0; i < 40 && bus.finish !== 1'b1; i++) cyc();
    bus.ld_en = 1'b1; bus.ld_addr = 6'd0; bus.ld_data = mw(7, 0, 0, 32'hC0DE);
    bus.start = 1'b1;
    cyc();
    bus.ld_en = 1'b0; bus.start = 1'b0;
    e = ex(0, 0, 0, 0, 0);
    n_total++;
    if (obs() !== e) $display("FAIL ld_start_edge: got %h want %h", obs(), e); else n_pass++;
    cyc();
    e = ex(32'hC0DE, 1, 0, 0, 0);
    n_total++;
    if (obs() !== e) $display("FAIL ld_start_fetch: got %h want %h", obs(), e); else n_pass++;
    cyc();
    e = ex(0, 0, 0, 1, 0);
    n_total++;
    if (obs() !== e) $display("FAIL ld_start_done: got %h want %h", obs(), e); else n_pass++;
  endtask

  task automatic test_random();
    logic [40:0] e;
    logic [41:0] d;
    logic [1:0]  fl;
    bit st, stl, ld;
    int la, op, md;
    for (int r = 0; r < 6; r++) begin
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 130; i++) begin
        md = $urandom_range(0, 7);
        if (md == 7 && $urandom_range(0, 2) != 0) md = 0;
        d  = mw(md, $urandom_range(0, 1), $urandom_range(0, 63), $urandom);
        if (i < 64) begin
          ld = 1; la = i; st = 0; stl = 0;
        end else begin
          st  = (i == 64) || ($urandom_range(0, 15) == 0);
          stl = ($urandom_range(0, 3) == 0);
          ld  = ($urandom_range(0, 7) == 0);
          la  = $urandom_range(0, 63);
        end
        fl = 2'($urandom_range(0, 3));
        op = $urandom_range(0, 63);
        bus.start = st; bus.stall = stl; bus.flags = fl; bus.opcode = 6'(op);
        bus.ld_en = ld; bus.ld_addr = 6'(la); bus.ld_data = d;
        model_step(st, stl, fl, op, ld, la, d);
        cyc();
        e = {m_ctrl, m_vld, 6'(m_upa), m_fin, m_err};
        n_total++;
        if (obs() !== e) $display("FAIL random r%0d c%0d: got %h want %h", r, i, obs(), e);
        else n_pass++;
      end
      bus.start = 0; bus.stall = 0; bus.ld_en = 0;
    end
  endtask

  initial begin
    test_reset();
    test_seq_chain();
    test_branch();
    test_dispatch_stall();
    test_stack();
    test_reset_mid_run();
    test_load_in_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end
endmodule
